// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with a two-entry skid buffer, synchronous flush
// and a saturating backpressure counter.
module pipe_stage_buf #(
    parameter int unsigned          PAYLOAD_W  = 32,
    parameter logic [PAYLOAD_W-1:0] CLR_VAL    = '0,
    parameter bit                   BUBBLE_CLR = 1'b1,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e               state_q;
    logic                 out_valid_q;
    logic                 in_ready_q;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [CNT_W-1:0]     cnt_q;

    logic acc;
    logic pop;
    logic stall;

    assign acc   = in_valid & in_ready_q;
    assign pop   = out_valid_q & out_ready;
    assign stall = out_valid_q & ~out_ready;

    // Handshake flags are kept as their own flops so no output is decoded from state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= CLR_VAL;
            skid_q      <= CLR_VAL;
            cnt_q       <= '0;
        end else begin
            if (stall && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (flush) begin
                // A coincident acc is dropped; a coincident pop has already completed downstream.
                state_q     <= StEmpty;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
                if (BUBBLE_CLR) begin
                    main_q <= CLR_VAL;
                    skid_q <= CLR_VAL;
                end
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (acc) begin
                            main_q      <= in_data;
                            state_q     <= StOne;
                            out_valid_q <= 1'b1;
                        end
                    end
                    StOne: begin
                        if (acc && pop) begin
                            main_q <= in_data;
                        end else if (acc) begin
                            skid_q     <= in_data;
                            state_q    <= StFull;
                            in_ready_q <= 1'b0;
                        end else if (pop) begin
                            state_q     <= StEmpty;
                            out_valid_q <= 1'b0;
                        end
                    end
                    StFull: begin
                        if (pop) begin
                            main_q     <= skid_q;
                            state_q    <= StOne;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (default and CNT_W=4/BUBBLE_CLR=0) driven in
// lockstep and compared against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam logic [31:0] Clr1 = 32'h0000_0000;
    localparam logic [31:0] Clr2 = 32'hDEAD_BEEF;
    localparam int unsigned Max1 = 65535;
    localparam int unsigned Max2 = 15;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready1, out_valid1, in_ready2, out_valid2;
    logic [31:0] out_data1, out_data2;
    logic [1:0]  occ1, occ2;
    logic [15:0] cnt1_o;
    logic [3:0]  cnt2_o;

    pipe_stage_buf #(
        .PAYLOAD_W  (32),
        .CLR_VAL    (Clr1),
        .BUBBLE_CLR (1'b1),
        .CNT_W      (16)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .occupancy (occ1),
        .stall_cnt (cnt1_o)
    );

    pipe_stage_buf #(
        .PAYLOAD_W  (32),
        .CLR_VAL    (Clr2),
        .BUBBLE_CLR (1'b0),
        .CNT_W      (4)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_data  (out_data2),
        .occupancy (occ2),
        .stall_cnt (cnt2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents plus the value the main register shows when empty.
    logic [31:0] mq[$];
    int unsigned mcnt1, mcnt2;
    logic [31:0] idle1, idle2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcnt1 = 0;
        mcnt2 = 0;
        idle1 = Clr1;
        idle2 = Clr2;
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = mq.size();
        chk({tag, " valid1"}, {31'b0, out_valid1}, {31'b0, n > 0});
        chk({tag, " ready1"}, {31'b0, in_ready1}, {31'b0, n < 2});
        chk({tag, " occ1"}, {30'b0, occ1}, n);
        chk({tag, " data1"}, out_data1, (n > 0) ? mq[0] : idle1);
        chk({tag, " cnt1"}, {16'b0, cnt1_o}, mcnt1);
        chk({tag, " valid2"}, {31'b0, out_valid2}, {31'b0, n > 0});
        chk({tag, " ready2"}, {31'b0, in_ready2}, {31'b0, n < 2});
        chk({tag, " occ2"}, {30'b0, occ2}, n);
        chk({tag, " data2"}, out_data2, (n > 0) ? mq[0] : idle2);
        chk({tag, " cnt2"}, {28'b0, cnt2_o}, mcnt2);
    endtask

    // Called at a negedge: drive inputs, advance model across posedge, check at next negedge.
    task automatic cycle(input string tag, input bit iv, input logic [31:0] d, input bit ordy,
                         input bit fl);
        bit acc, pop, stall;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc   = iv && (mq.size() < 2);
        pop   = (mq.size() > 0) && ordy;
        stall = (mq.size() > 0) && !ordy;
        @(posedge clk);
        if (stall) begin
            if (mcnt1 < Max1) mcnt1++;
            if (mcnt2 < Max2) mcnt2++;
        end
        if (fl) begin
            idle1 = Clr1;
            if (mq.size() > 0) idle2 = mq[0];
            mq.delete();
        end else begin
            if (pop) begin
                idle1 = mq[0];
                idle2 = mq[0];
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            check_all("reset");
        end
        reset = 1'b1;

        // First transfer
        cycle("first", 1'b1, 32'h0000_3000, 1'b1, 1'b0);
        cycle("first_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // Back-to-back streaming
        for (int i = 0; i < 8; i++) cycle("stream", 1'b1, 32'h10 + i, 1'b1, 1'b0);
        cycle("stream_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: stall_cnt reaches 6
        cycle("bp_a", 1'b1, 32'hA, 1'b0, 1'b0);
        cycle("bp_b", 1'b1, 32'hB, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("bp_hold", 1'b1, 32'hC, 1'b0, 1'b0);
        chk("bp_cnt6", {16'b0, cnt1_o}, 32'd6);
        for (int i = 0; i < 3; i++) cycle("bp_release", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL with coincident pop
        cycle("fl_a", 1'b1, 32'hA, 1'b0, 1'b0);
        cycle("fl_b", 1'b1, 32'hB, 1'b0, 1'b0);
        cycle("fl_pop", 1'b0, 32'h0, 1'b1, 1'b1);
        chk("fl_clr", out_data1, Clr1);

        // Flush with coincident acc
        cycle("fa_one", 1'b1, 32'h33, 1'b0, 1'b0);
        cycle("fa_acc", 1'b1, 32'h55, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("fa_after", 1'b0, 32'h0, 1'b1, 1'b0);
            chk("fa_no55", {31'b0, out_valid1 && (out_data1 == 32'h55)}, 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        // Saturation on the 4-bit counter
        cycle("sat_fill", 1'b1, 32'h77, 1'b0, 1'b1);
        cycle("sat_load", 1'b1, 32'h78, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("sat_hold", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat_cnt15", {28'b0, cnt2_o}, 32'd15);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        check_all("async_hold");
        reset = 1'b1;
        cycle("post_rst", 1'b1, 32'h99, 1'b1, 1'b0);
        cycle("post_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the plain enable-gated inter-stage pipeline register.
- Carries a PAYLOAD_W-bit bundle between two pipeline stages using a valid/ready handshake, with a two-entry skid buffer so the upstream ready does not depend combinationally on the downstream ready.
- Synchronous flush inserts bubbles.
- A saturating counter reports backpressure cycles for performance debug.

Parameters:
- PAYLOAD_W, 32: width of the payload bundle (instr, PC, operands, etc. packed by the instantiating stage).
- CLR_VAL, 0: payload value loaded on reset and, when BUBBLE_CLR=1, on flush.
- BUBBLE_CLR, 1: 1 means flush also writes CLR_VAL into both payload registers; 0 means flush clears only the valid bits.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream holds a valid payload
- in_ready  out  1  buffer can accept; driven only from registered state
- in_data  in  PAYLOAD_W  upstream payload
- flush  in  1  synchronous kill of all buffered entries
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts this cycle
- out_data  out  PAYLOAD_W  payload from the main register
- occupancy  out  2  number of held entries: 0, 1 or 2
- stall_cnt  out  CNT_W  saturating count of backpressure cycles

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
  - Main and skid payload registers are set to CLR_VAL.
  - Deassertion is sampled at the next clk edge; no transfer occurs in a reset cycle.
- Definitions:
  - acc = in_valid & in_ready
  - pop = out_valid & out_ready
- Storage:
  - Main register drives out_data and out_valid.
  - Skid register is internal.
  - in_ready = ~skid_valid.
- States are encoded by occupancy: EMPTY(0), ONE(1), FULL(2).
- Transitions at posedge, when flush=0:
  - EMPTY, acc: main<=in_data, go to ONE.
  - EMPTY, no acc: stay in EMPTY.
  - ONE, acc and pop: main<=in_data, stay in ONE.
  - ONE, acc and no pop: skid<=in_data, go to FULL.
  - ONE, pop and no acc: go to EMPTY.
  - ONE, neither: hold.
  - FULL (in_ready=0, so acc is impossible), pop: main<=skid, go to ONE.
  - FULL, no pop: hold.
- Ordering:
  - Strict FIFO order is preserved.
  - No entry is duplicated or dropped except by flush.
- Timing:
  - Latency is 1 cycle from acc to out_valid when EMPTY.
  - Sustained throughput is 1 entry/cycle with out_ready held high.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Flush (synchronous, highest priority after reset):
  - Next state is EMPTY.
  - A coincident acc is discarded, even though upstream saw the handshake; upstream must treat flush as killing that entry.
  - A coincident pop still completes downstream; the buffer simply empties.
  - If BUBBLE_CLR=1, both payload registers <= CLR_VAL; otherwise payload registers hold.
- stall_cnt:
  - Increments by 1 in each cycle where out_valid=1 and out_ready=0, including a flush cycle.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Payload is stored unmodified and is never interpreted; widths are exact, with no padding.
- out_valid, in_ready and occupancy are all registered outputs.

Test Plan:
- Reset and first transfer: hold reset=0 for 3 cycles, release, then drive in_valid=1, in_data=0x00003000 for one cycle → the next cycle has out_valid=1, out_data=0x00003000, occupancy=1; during reset in_ready=1 and out_data=CLR_VAL.
- Back-to-back streaming: feed 0x10,0x11,…,0x17 on consecutive cycles with out_ready=1 → outputs 0x10..0x17 appear on consecutive cycles, occupancy stays 1, stall_cnt=0.
- Backpressure: with out_ready=0, send 0xA then 0xB → occupancy=2, in_ready=0, out_data=0xA; keep out_ready=0 for 5 cycles → stall_cnt=6; raise out_ready → 0xA then 0xB are popped, then occupancy=0.
- Flush while FULL with a coincident pop: occupancy=2 (0xA, 0xB), then flush=1 and out_ready=1 in the same cycle → 0xA is popped, the next cycle has occupancy=0, out_valid=0, in_ready=1, and out_data=CLR_VAL (BUBBLE_CLR=1).
- Flush with a coincident acc: occupancy=1, then in_valid=1, in_data=0x55 and flush=1 → the next cycle has occupancy=0 and 0x55 is never output.
- Saturation and asynchronous reset: CNT_W=4, stall held for 20 cycles → stall_cnt=15; assert reset mid-cycle → all outputs reach their reset values before the next clk edge.
